// File: rtl/memory_island_bank_arbiter_if.sv
// Request/response bundle between the island interconnect, one arbiter and one bank.
// master = requesters plus bank data return; slave = arbiter.
interface memory_island_bank_arbiter_if #(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 64,
   parameter int NumNarrow = 4
);
   logic [NumNarrow-1:0]                  narrow_req_i;
   logic [NumNarrow-1:0]                  narrow_gnt_o;
   logic [NumNarrow-1:0][AddrWidth-1:0]   narrow_addr_i;
   logic [NumNarrow-1:0]                  narrow_we_i;
   logic [NumNarrow-1:0][DataWidth-1:0]   narrow_wdata_i;
   logic [NumNarrow-1:0][DataWidth/8-1:0] narrow_strb_i;
   logic [NumNarrow-1:0]                  narrow_rvalid_o;
   logic [DataWidth-1:0]                  narrow_rdata_o;

   logic                   wide_req_i;
   logic                   wide_gnt_o;
   logic [AddrWidth-1:0]   wide_addr_i;
   logic                   wide_we_i;
   logic [DataWidth-1:0]   wide_wdata_i;
   logic [DataWidth/8-1:0] wide_strb_i;
   logic                   wide_rvalid_o;
   logic [DataWidth-1:0]   wide_rdata_o;

   logic                   bank_req_o;
   logic [AddrWidth-1:0]   bank_addr_o;
   logic                   bank_we_o;
   logic [DataWidth-1:0]   bank_wdata_o;
   logic [DataWidth/8-1:0] bank_be_o;
   logic [DataWidth-1:0]   bank_rdata_i;

   modport master (
      output narrow_req_i, narrow_addr_i, narrow_we_i,
      output narrow_wdata_i, narrow_strb_i,
      input  narrow_gnt_o, narrow_rvalid_o, narrow_rdata_o,
      output wide_req_i, wide_addr_i, wide_we_i,
      output wide_wdata_i, wide_strb_i,
      input  wide_gnt_o, wide_rvalid_o, wide_rdata_o,
      input  bank_req_o, bank_addr_o, bank_we_o,
      input  bank_wdata_o, bank_be_o,
      output bank_rdata_i
   );

   modport slave (
      input  narrow_req_i, narrow_addr_i, narrow_we_i,
      input  narrow_wdata_i, narrow_strb_i,
      output narrow_gnt_o, narrow_rvalid_o, narrow_rdata_o,
      input  wide_req_i, wide_addr_i, wide_we_i,
      input  wide_wdata_i, wide_strb_i,
      output wide_gnt_o, wide_rvalid_o, wide_rdata_o,
      output bank_req_o, bank_addr_o, bank_we_o,
      output bank_wdata_o, bank_be_o,
      input  bank_rdata_i
   );
endinterface

// File: rtl/memory_island_bank_arbiter.sv
// Per-bank arbiter: round-robin narrow ports, one wide port with starvation escape.
// MEMORY_ISLAND_BANK_ARB_STATS_EN enables the contention counter.
module memory_island_bank_arbiter #(
   parameter int AddrWidth        = 32,
   parameter int DataWidth        = 64,
   parameter int NumNarrow        = 4,
   parameter int WidePriorityWait = 0,
   parameter int StatsWidth       = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   memory_island_bank_arbiter_if.slave bus,
   output logic [StatsWidth-1:0] conflict_cnt_o
);

   localparam int IdxW  = (NumNarrow > 1) ? $clog2(NumNarrow) : 1;
   localparam int WaitW = (WidePriorityWait > 0) ?
                          $clog2(WidePriorityWait + 1) : 1;
   localparam logic [WaitW-1:0] WaitMax = WaitW'(WidePriorityWait);
   localparam logic [IdxW-1:0]  LastIdx = IdxW'(NumNarrow - 1);

   logic [IdxW-1:0]  rr_q;
   logic [WaitW-1:0] wait_q;
   logic             rsp_valid_q;
   logic             rsp_wide_q;
   logic [IdxW-1:0]  rsp_idx_q;

   logic            n_found;
   logic [IdxW-1:0] n_idx;
   int unsigned     cand;
   logic            wide_prio;
   logic            wide_win;
   logic            narrow_win;

   always_comb begin
      n_found = 1'b0;
      n_idx   = '0;
      cand    = 0;
      for (int i = 0; i < NumNarrow; i++) begin
         cand = (int'(rr_q) + i) % NumNarrow;
         if (!n_found && bus.narrow_req_i[cand[IdxW-1:0]]) begin
            n_found = 1'b1;
            n_idx   = cand[IdxW-1:0];
         end
      end
   end

   assign wide_prio  = (WidePriorityWait != 0) && (wait_q == WaitMax);
   assign wide_win   = !rst_i && bus.wide_req_i && (!n_found || wide_prio);
   assign narrow_win = !rst_i && n_found && !wide_win;

   always_comb begin
      bus.narrow_gnt_o = '0;
      if (narrow_win) bus.narrow_gnt_o[n_idx] = 1'b1;
   end

   assign bus.wide_gnt_o = wide_win;
   assign bus.bank_req_o = wide_win || narrow_win;

   always_comb begin
      bus.bank_addr_o  = bus.narrow_addr_i[n_idx];
      bus.bank_we_o    = bus.narrow_we_i[n_idx];
      bus.bank_wdata_o = bus.narrow_wdata_i[n_idx];
      bus.bank_be_o    = bus.narrow_strb_i[n_idx];
      if (wide_win) begin
         bus.bank_addr_o  = bus.wide_addr_i;
         bus.bank_we_o    = bus.wide_we_i;
         bus.bank_wdata_o = bus.wide_wdata_i;
         bus.bank_be_o    = bus.wide_strb_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_q        <= '0;
         wait_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_wide_q  <= 1'b0;
         rsp_idx_q   <= '0;
      end else begin
         rsp_valid_q <= wide_win || narrow_win;
         rsp_wide_q  <= wide_win;
         rsp_idx_q   <= n_idx;
         if (narrow_win)
            rr_q <= (n_idx == LastIdx) ? '0 : n_idx + 1'b1;
         if (WidePriorityWait == 0 || !bus.wide_req_i || wide_win)
            wait_q <= '0;
         else if (wait_q != WaitMax)
            wait_q <= wait_q + 1'b1;
      end
   end

   // Responses are masked during reset so a pending beat never escapes.
   always_comb begin
      bus.narrow_rvalid_o = '0;
      if (!rst_i && rsp_valid_q && !rsp_wide_q)
         bus.narrow_rvalid_o[rsp_idx_q] = 1'b1;
   end

   assign bus.wide_rvalid_o  = !rst_i && rsp_valid_q && rsp_wide_q;
   assign bus.narrow_rdata_o = bus.bank_rdata_i;
   assign bus.wide_rdata_o   = bus.bank_rdata_i;

`ifdef MEMORY_ISLAND_BANK_ARB_STATS_EN
   logic [StatsWidth-1:0] cnt_q;
   int unsigned           n_busy;

   always_comb begin
      n_busy = bus.wide_req_i ? 1 : 0;
      for (int i = 0; i < NumNarrow; i++)
         n_busy = n_busy + (bus.narrow_req_i[i] ? 1 : 0);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)            cnt_q <= '0;
      else if (n_busy >= 2) cnt_q <= cnt_q + 1'b1;
   end

   assign conflict_cnt_o = cnt_q;
`else
   assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_memory_island_bank_arbiter.sv
// Bench: two arbiters (wait 0 and wait 3) on shared stimulus,
// checked against a queue-free behavioural model of the arbitration rules.
module tb_memory_island_bank_arbiter;

   localparam int AW = 32;
   localparam int DW = 64;
   localparam int NN = 4;
   localparam int SW = 16;
   localparam int WT [2] = '{0, 3};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NN-1:0]              n_req;
   logic [NN-1:0][AW-1:0]      n_addr;
   logic [NN-1:0]              n_we;
   logic [NN-1:0][DW-1:0]      n_wdata;
   logic [NN-1:0][DW/8-1:0]    n_strb;
   logic                       w_req;
   logic [AW-1:0]              w_addr;
   logic                       w_we;
   logic [DW-1:0]              w_wdata;
   logic [DW/8-1:0]            w_strb;
   logic [DW-1:0]              b_rdata;
   logic [SW-1:0]              cnt0, cnt3;

   memory_island_bank_arbiter_if #(
      .AddrWidth(AW), .DataWidth(DW), .NumNarrow(NN)) if0 ();
   memory_island_bank_arbiter_if #(
      .AddrWidth(AW), .DataWidth(DW), .NumNarrow(NN)) if3 ();

   assign if0.narrow_req_i   = n_req;
   assign if0.narrow_addr_i  = n_addr;
   assign if0.narrow_we_i    = n_we;
   assign if0.narrow_wdata_i = n_wdata;
   assign if0.narrow_strb_i  = n_strb;
   assign if0.wide_req_i     = w_req;
   assign if0.wide_addr_i    = w_addr;
   assign if0.wide_we_i      = w_we;
   assign if0.wide_wdata_i   = w_wdata;
   assign if0.wide_strb_i    = w_strb;
   assign if0.bank_rdata_i   = b_rdata;

   assign if3.narrow_req_i   = n_req;
   assign if3.narrow_addr_i  = n_addr;
   assign if3.narrow_we_i    = n_we;
   assign if3.narrow_wdata_i = n_wdata;
   assign if3.narrow_strb_i  = n_strb;
   assign if3.wide_req_i     = w_req;
   assign if3.wide_addr_i    = w_addr;
   assign if3.wide_we_i      = w_we;
   assign if3.wide_wdata_i   = w_wdata;
   assign if3.wide_strb_i    = w_strb;
   assign if3.bank_rdata_i   = b_rdata;

   memory_island_bank_arbiter #(
      .AddrWidth(AW), .DataWidth(DW), .NumNarrow(NN),
      .WidePriorityWait(0), .StatsWidth(SW)
   ) u_dut0 (
      .clk_i(clk), .rst_i(rst), .bus(if0.slave), .conflict_cnt_o(cnt0)
   );

   memory_island_bank_arbiter #(
      .AddrWidth(AW), .DataWidth(DW), .NumNarrow(NN),
      .WidePriorityWait(3), .StatsWidth(SW)
   ) u_dut3 (
      .clk_i(clk), .rst_i(rst), .bus(if3.slave), .conflict_cnt_o(cnt3)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // model state: winner 0..NN-1 narrow, NN wide, -1 none
   int m_rr [2];
   int m_wait [2];
   int m_pend [2];
   int m_win [2];
   int m_cnt [2];

   logic [NN-1:0] ob_gn [2];
   logic          ob_gw [2];
   logic [NN-1:0] ob_rvn [2];
   logic [SW-1:0] ob_cnt [2];

   function automatic int model_win(int d);
      int first = -1;
      if (rst) return -1;
      for (int i = 0; i < NN; i++)
         if (first < 0 && n_req[(m_rr[d] + i) % NN]) first = (m_rr[d] + i) % NN;
      if (w_req && (first < 0 || (WT[d] != 0 && m_wait[d] == WT[d])))
         return NN;
      return first;
   endfunction

   function automatic int n_busy();
      int c = w_req ? 1 : 0;
      for (int i = 0; i < NN; i++) c += n_req[i] ? 1 : 0;
      return c;
   endfunction

   task automatic check_inst(
      input int d, input logic [NN-1:0] gn, input logic gw,
      input logic br, input logic [AW-1:0] ba, input logic bwe,
      input logic [DW-1:0] bwd, input logic [DW/8-1:0] bbe,
      input logic [NN-1:0] rvn, input logic rvw,
      input logic [DW-1:0] rdn, input logic [DW-1:0] rdw,
      input logic [SW-1:0] cnt);
      int w;
      logic [NN-1:0] egn;
      logic [NN-1:0] ervn;
      w = model_win(d);
      m_win[d] = w;
      egn = '0;
      if (w >= 0 && w < NN) egn[w] = 1'b1;
      chk($sformatf("gnt_n%0d", d), 64'(gn), 64'(egn));
      chk($sformatf("gnt_w%0d", d), 64'(gw), 64'(w == NN));
      chk($sformatf("bank_req%0d", d), 64'(br), 64'(w >= 0));
      if (w == NN) begin
         chk($sformatf("addr_w%0d", d), 64'(ba), 64'(w_addr));
         chk($sformatf("we_w%0d", d), 64'(bwe), 64'(w_we));
         chk($sformatf("wd_w%0d", d), bwd, w_wdata);
         chk($sformatf("be_w%0d", d), 64'(bbe), 64'(w_strb));
      end else if (w >= 0) begin
         chk($sformatf("addr_n%0d", d), 64'(ba), 64'(n_addr[w]));
         chk($sformatf("we_n%0d", d), 64'(bwe), 64'(n_we[w]));
         chk($sformatf("wd_n%0d", d), bwd, n_wdata[w]);
         chk($sformatf("be_n%0d", d), 64'(bbe), 64'(n_strb[w]));
      end
      ervn = '0;
      if (!rst && m_pend[d] >= 0 && m_pend[d] < NN) ervn[m_pend[d]] = 1'b1;
      chk($sformatf("rv_n%0d", d), 64'(rvn), 64'(ervn));
      chk($sformatf("rv_w%0d", d), 64'(rvw), 64'(!rst && m_pend[d] == NN));
      if (rvn != '0) chk($sformatf("rd_n%0d", d), rdn, b_rdata);
      if (rvw) chk($sformatf("rd_w%0d", d), rdw, b_rdata);
`ifdef MEMORY_ISLAND_BANK_ARB_STATS_EN
      chk($sformatf("cnt%0d", d), 64'(cnt), 64'(m_cnt[d]));
`else
      chk($sformatf("cnt%0d", d), 64'(cnt), 64'd0);
`endif
      ob_gn[d] = gn; ob_gw[d] = gw; ob_rvn[d] = rvn; ob_cnt[d] = cnt;
   endtask

   task automatic model_clock(input int d);
      if (rst) begin
         m_rr[d] = 0; m_wait[d] = 0; m_pend[d] = -1; m_cnt[d] = 0;
      end else begin
         m_pend[d] = m_win[d];
         if (m_win[d] >= 0 && m_win[d] < NN) m_rr[d] = (m_win[d] + 1) % NN;
         if (WT[d] == 0 || !w_req || m_win[d] == NN) m_wait[d] = 0;
         else if (m_wait[d] < WT[d]) m_wait[d]++;
         if (n_busy() >= 2) m_cnt[d] = (m_cnt[d] + 1) % (1 << SW);
      end
   endtask

   task automatic step();
      @(negedge clk);
      check_inst(0, if0.narrow_gnt_o, if0.wide_gnt_o, if0.bank_req_o,
                 if0.bank_addr_o, if0.bank_we_o, if0.bank_wdata_o,
                 if0.bank_be_o, if0.narrow_rvalid_o, if0.wide_rvalid_o,
                 if0.narrow_rdata_o, if0.wide_rdata_o, cnt0);
      check_inst(1, if3.narrow_gnt_o, if3.wide_gnt_o, if3.bank_req_o,
                 if3.bank_addr_o, if3.bank_we_o, if3.bank_wdata_o,
                 if3.bank_be_o, if3.narrow_rvalid_o, if3.wide_rvalid_o,
                 if3.narrow_rdata_o, if3.wide_rdata_o, cnt3);
      @(posedge clk);
      model_clock(0);
      model_clock(1);
      #1;
      b_rdata = {$urandom, $urandom};
   endtask

   task automatic rand_payload();
      for (int i = 0; i < NN; i++) begin
         n_addr[i]  = $urandom;
         n_we[i]    = 1'($urandom);
         n_wdata[i] = {$urandom, $urandom};
         n_strb[i]  = 8'($urandom);
      end
      w_addr  = $urandom;
      w_we    = 1'($urandom);
      w_wdata = {$urandom, $urandom};
      w_strb  = 8'($urandom);
   endtask

   task automatic do_reset();
      rst = 1'b1; n_req = '0; w_req = 1'b0;
      step();
      rst = 1'b0;
   endtask

   int wide_hits;

   initial begin
      for (int d = 0; d < 2; d++) begin
         m_rr[d] = 0; m_wait[d] = 0; m_pend[d] = -1; m_cnt[d] = 0;
      end
      n_req = '0; w_req = 1'b0; b_rdata = '0;
      rand_payload();
      @(posedge clk); #1;
      step(); step();
      chk("rst_gnt", 64'(ob_gn[0]), 64'd0);
      rst = 1'b0;

      // single narrow read
      n_req = 4'b0100; n_addr[2] = 32'h10; n_we[2] = 1'b0;
      step();
      chk("single_gnt", 64'(ob_gn[0]), 64'h4);
      n_req = '0;
      step();
      chk("single_rv", 64'(ob_rvn[0]), 64'h4);

      // round robin from reset
      do_reset();
      n_req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("rr_gnt", 64'(ob_gn[0]), 64'(1 << (k % 4)));
         if (k > 0) chk("rr_rv", 64'(ob_rvn[0]), 64'(1 << ((k - 1) % 4)));
      end
      n_req = '0;
      step();
      chk("rr_rv_last", 64'(ob_rvn[0]), 64'h1);

      // wide starvation escape at wait 3
      do_reset();
      w_req = 1'b1; n_req = 4'b0001;
      for (int k = 1; k <= 6; k++) begin
         step();
         chk("starve_w3", 64'(ob_gw[1]), 64'(k == 4));
         chk("starve_n3", 64'(ob_gn[1]), 64'(k == 4 ? 0 : 1));
         chk("starve_w0", 64'(ob_gw[0]), 64'd0);
      end

      // wait 0: narrow never relinquishes
      wide_hits = 0;
      for (int k = 0; k < 100; k++) begin
         n_req = 4'($urandom_range(1, 15));
         rand_payload();
         step();
         if (ob_gw[0]) wide_hits++;
      end
      chk("w0_never", 64'(wide_hits), 64'd0);
      n_req = '0;
      step();
      chk("w0_idle_w", 64'(ob_gw[0]), 64'd1);
      chk("w3_idle_w", 64'(ob_gw[1]), 64'd1);

      // reset while a response is pending
      do_reset();
      n_req = 4'b0100;
      step();
      chk("mid_gnt", 64'(ob_gn[0]), 64'h4);
      rst = 1'b1; n_req = '0;
      step();
      chk("mid_rv", 64'(ob_rvn[0]), 64'd0);
      rst = 1'b0;
      step();
      chk("mid_rv2", 64'(ob_rvn[0]), 64'd0);
      n_req = 4'b1111;
      step();
      chk("mid_first", 64'(ob_gn[0]), 64'h1);

      // conflict statistics
      do_reset();
      n_req = 4'b0011;
      for (int k = 0; k < 10; k++) step();
      n_req = '0;
      step();
`ifdef MEMORY_ISLAND_BANK_ARB_STATS_EN
      chk("stats10", 64'(ob_cnt[1]), 64'd10);
`else
      chk("stats0", 64'(ob_cnt[1]), 64'd0);
`endif

      // random traffic with occasional resets
      for (int k = 0; k < 3000; k++) begin
         rst   = ($urandom_range(0, 63) == 0);
         n_req = 4'($urandom);
         w_req = ($urandom_range(0, 2) != 0);
         rand_payload();
         step();
      end
      rst = 1'b0; n_req = '0; w_req = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
